// File: rtl/serial_result_collector.sv
// serial_result_collector
//
// Collects the LSB-first output of an upstream bit-serial adder into a
// parallel result, derives carry-out, signed overflow and zero flags, and
// presents the result with a valid/ready handshake.
//
// Ports:
//   clk    in   rising-edge clock for all state
//   rst    in   asynchronous active-high reset
//   start  in   one-cycle pulse that begins a collection (honoured in IDLE,
//               or in HOLD on the same edge the result is accepted)
//   s_bit  in   serial sum bit, LSB first
//   c_bit  in   carry-out of the upstream full adder for the same bit
//   ready  in   downstream accepts the held result while valid is high
//   sum    out  WIDTH-bit registered result (last completed operation)
//   cout   out  carry-out of the MSB
//   ovf    out  signed overflow (carry into MSB xor carry out of MSB)
//   zero   out  collected sum is all zeros
//   valid  out  result is being presented (HOLD)
//   busy   out  bits are being collected (SHIFT)
//
// WIDTH must be at least 2 so that a distinct carry-into-MSB bit exists.

module serial_result_collector #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             s_bit,
  input  logic             c_bit,
  input  logic             ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero,
  output logic             valid,
  output logic             busy
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT    = CW'(WIDTH - 1);
  localparam logic [CW-1:0] PRELAST_BIT = CW'(WIDTH - 2);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [CW-1:0]    bit_cnt;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] shifted;
  logic             msb_cin;
  logic             launch;

  // The incoming bit enters at the top and everything moves right, so after
  // WIDTH shifts the first (LSB) bit has arrived at position 0.
  assign shifted = {s_bit, shreg[WIDTH-1:1]};

  // A new collection is launched from IDLE on start, or straight out of HOLD
  // when the current result is accepted on the same edge start is seen.
  assign launch = start && ((state == IDLE) || ((state == HOLD) && ready));

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode. start is deliberately not looked at in SHIFT, and in
  // HOLD it only matters on the accepting edge.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        if (bit_cnt == LAST_BIT) begin
          state_next = HOLD;
        end
      end
      HOLD: begin
        if (ready) begin
          state_next = start ? SHIFT : IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Collection datapath. The carry captured with bit WIDTH-2 is the carry
  // into the MSB; combined with the final carry it gives signed overflow.
  // The result registers only change on the final bit edge, so they hold the
  // last completed result through HOLD, IDLE and the next SHIFT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt <= '0;
      shreg   <= '0;
      msb_cin <= 1'b0;
      sum     <= '0;
      cout    <= 1'b0;
      ovf     <= 1'b0;
      zero    <= 1'b0;
    end else if (state == SHIFT) begin
      shreg <= shifted;
      if (bit_cnt == PRELAST_BIT) begin
        msb_cin <= c_bit;
      end
      if (bit_cnt == LAST_BIT) begin
        bit_cnt <= '0;
        sum     <= shifted;
        cout    <= c_bit;
        ovf     <= c_bit ^ msb_cin;
        zero    <= (shifted == '0);
      end else begin
        bit_cnt <= bit_cnt + CW'(1);
      end
    end else if (launch) begin
      bit_cnt <= '0;
    end
  end

  assign busy  = (state == SHIFT);
  assign valid = (state == HOLD);

endmodule

// File: tb/tb_serial_result_collector.sv
// tb_serial_result_collector
//
// Drives serial bits produced by a reference ripple adder into
// serial_result_collector. Each operation pushes its hand-computed result
// into a queue; a monitor pops and compares whenever a result is accepted
// (valid && ready). Timing, backpressure and reset behaviour are checked
// directly from the stimulus thread.

module tb_serial_result_collector;

  logic       clk;
  logic       rst;
  logic       start;
  logic       s_bit;
  logic       c_bit;
  logic       ready;
  logic [7:0] sum;
  logic       cout;
  logic       ovf;
  logic       zero;
  logic       valid;
  logic       busy;

  int checks = 0;
  int errors = 0;

  // Expected {sum, cout, ovf, zero} for each issued operation.
  logic [10:0] exp_q[$];

  serial_result_collector #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .s_bit (s_bit),
    .c_bit (c_bit),
    .ready (ready),
    .sum   (sum),
    .cout  (cout),
    .ovf   (ovf),
    .zero  (zero),
    .valid (valid),
    .busy  (busy)
  );

  // 10 time-unit clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case the run ever stalls.
  initial begin
    #200000;
    $display("[TB] FAIL timeout simulation did not complete");
    $fatal(1, "[TB] timeout");
  end

  // Reference bit-serial ripple adder: returns {carry bits, sum bits}.
  function automatic logic [15:0] refAdd(input logic [7:0] a, input logic [7:0] b);
    logic       c;
    logic [7:0] s;
    logic [7:0] co;
    c = 1'b0;
    for (int i = 0; i < 8; i++) begin
      s[i]  = a[i] ^ b[i] ^ c;
      co[i] = (a[i] & b[i]) | (a[i] & c) | (b[i] & c);
      c     = co[i];
    end
    return {co, s};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Inputs change 2 units after the rising edge; the monitor samples on the
  // falling edge.
  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic startOp;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Feed nbits serial bits; optionally pulse start at bit index mid_start
  // to confirm it has no effect while shifting.
  task automatic shiftBits(input logic [7:0] a, input logic [7:0] b,
                           input int nbits, input int mid_start);
    logic [15:0] r;
    r = refAdd(a, b);
    for (int i = 0; i < nbits; i++) begin
      s_bit = r[i];
      c_bit = r[8 + i];
      start = (i == mid_start);
      if (nbits == 8 && i == 7) begin
        checkOutput("valid_before_last_bit", {31'd0, valid}, 32'd0);
      end
      tick();
    end
    start = 1'b0;
    s_bit = 1'b0;
    c_bit = 1'b0;
  endtask

  // One full operation: queue the expected result, launch, shift all bits
  // and check valid rises on the 9th edge counting the start edge.
  task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b,
                               input logic [7:0] e_sum, input logic e_cout,
                               input logic e_ovf, input logic e_zero,
                               input int mid_start);
    exp_q.push_back({e_sum, e_cout, e_ovf, e_zero});
    startOp();
    checkOutput("busy_after_start", {31'd0, busy}, 32'd1);
    shiftBits(a, b, 8, mid_start);
    checkOutput("valid_after_9_edges", {31'd0, valid}, 32'd1);
    checkOutput("busy_in_hold", {31'd0, busy}, 32'd0);
  endtask

  task automatic checkIdle(input logic [7:0] e_sum);
    checkOutput("idle_valid", {31'd0, valid}, 32'd0);
    checkOutput("idle_busy", {31'd0, busy}, 32'd0);
    checkOutput("idle_sum_retained", {24'd0, sum}, {24'd0, e_sum});
  endtask

  // Scoreboard monitor: compares on every accepted result.
  always @(negedge clk) begin
    if (!rst && valid && ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("[TB] FAIL unexpected_result actual=%0h expected=none", {sum, cout, ovf, zero});
      end else begin
        logic [10:0] e;
        e = exp_q.pop_front();
        if ({sum, cout, ovf, zero} !== e) begin
          errors++;
          $display("[TB] FAIL result actual sum=%0h cout=%0b ovf=%0b zero=%0b expected sum=%0h cout=%0b ovf=%0b zero=%0b",
                   sum, cout, ovf, zero, e[10:3], e[2], e[1], e[0]);
        end
      end
    end
  end

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    s_bit = 1'b0;
    c_bit = 1'b0;
    ready = 1'b1;
    #1;
    checkOutput("reset_sum", {24'd0, sum}, 32'd0);
    checkOutput("reset_flags", {28'd0, cout, ovf, zero, valid}, 32'd0);
    checkOutput("reset_busy", {31'd0, busy}, 32'd0);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst = 1'b0;

    // First edge after reset release samples start directly.
    applyStimulus(8'd55, 8'd31, 8'h56, 1'b0, 1'b0, 1'b0, -1);
    tick();
    checkIdle(8'h56);

    // Signed overflow, with a stray start pulse in the middle of SHIFT.
    applyStimulus(8'd127, 8'd1, 8'h80, 1'b0, 1'b1, 1'b0, 3);
    tick();
    checkIdle(8'h80);

    // Wrap to zero with carry-out.
    applyStimulus(8'd255, 8'd1, 8'h00, 1'b1, 1'b0, 1'b1, -1);
    tick();
    checkIdle(8'h00);
    checkOutput("zero_retained", {31'd0, zero}, 32'd1);

    // Backpressure: result must hold and start must be ignored.
    ready = 1'b0;
    applyStimulus(8'd100, 8'd27, 8'h7F, 1'b0, 1'b0, 1'b0, -1);
    for (int k = 0; k < 5; k++) begin
      start = (k % 2 == 0);
      tick();
      checkOutput("bp_valid", {31'd0, valid}, 32'd1);
      checkOutput("bp_busy", {31'd0, busy}, 32'd0);
      checkOutput("bp_result", {21'd0, sum, cout, ovf, zero}, {21'd0, 8'h7F, 3'b000});
    end
    start = 1'b0;
    ready = 1'b1;
    tick();
    checkIdle(8'h7F);

    // Back-to-back: second launch happens on the accepting edge.
    applyStimulus(8'd1, 8'd2, 8'h03, 1'b0, 1'b0, 1'b0, -1);
    applyStimulus(8'd16, 8'd16, 8'h20, 1'b0, 1'b0, 1'b0, -1);
    tick();
    checkIdle(8'h20);

    // Reset after four bits discards the partial operation.
    startOp();
    shiftBits(8'd200, 8'd100, 4, -1);
    rst = 1'b1;
    #1;
    checkOutput("midreset_sum", {24'd0, sum}, 32'd0);
    checkOutput("midreset_flags", {28'd0, cout, ovf, zero, valid}, 32'd0);
    checkOutput("midreset_busy", {31'd0, busy}, 32'd0);
    tick();
    rst = 1'b0;
    tick();
    checkIdle(8'h00);
    tick();
    checkIdle(8'h00);
    applyStimulus(8'd200, 8'd100, 8'h2C, 1'b1, 1'b0, 1'b0, -1);
    tick();
    checkIdle(8'h2C);

    checkOutput("queue_drained", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
